// File: rtl/k1_pulse_checker_pkg.sv
// Shared types and constants for the K1 pulse loopback checker.
// Package k1_chk_pkg: FSM states, fail codes, tally width.
package k1_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE
  } state_t;

  localparam logic [1:0] FC_OK       = 2'd0;
  localparam logic [1:0] FC_NO_PULSE = 2'd1;
  localparam logic [1:0] FC_WIDTH    = 2'd2;
  localparam logic [1:0] FC_STUCK    = 2'd3;

  localparam int TALLY_W = 16;

  function automatic logic [TALLY_W-1:0] sat_inc(
    input logic [TALLY_W-1:0] v
  );
    return (v == {TALLY_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/k1_pulse_checker_if.sv
// Fixture-side bundle of the K1 pulse checker.
// master drives trigger/sense/enable, slave is the checker.
interface k1_pulse_checker_if #(
  parameter int CNT_W = 16
) ();
  import k1_chk_pkg::*;

  logic               enable;
  logic               tem;
  logic               k1_sense;
  logic               busy;
  logic               done;
  logic               pass;
  logic [1:0]         fail_code;
  logic [CNT_W-1:0]   delay_cnt;
  logic [CNT_W-1:0]   width_cnt;
  logic [TALLY_W-1:0] pass_count;
  logic [TALLY_W-1:0] fail_count;

  modport master (
    output enable,
    output tem,
    output k1_sense,
    input  busy,
    input  done,
    input  pass,
    input  fail_code,
    input  delay_cnt,
    input  width_cnt,
    input  pass_count,
    input  fail_count
  );

  modport slave (
    input  enable,
    input  tem,
    input  k1_sense,
    output busy,
    output done,
    output pass,
    output fail_code,
    output delay_cnt,
    output width_cnt,
    output pass_count,
    output fail_count
  );

endinterface

// File: rtl/k1_pulse_checker_sync_edge.sv
// Two-flop synchroniser, optional deglitch filter, rise detect.
// The filter is active only when FILT_EN is set by the top.
module sync_edge #(
  parameter bit FILT_EN  = 1'b0,
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic s1;
  logic s2;
  logic q;
  logic q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  generate
    if (FILT_EN && FILT_LEN > 0) begin : g_filt
      localparam int CW = $clog2(FILT_LEN + 1);
      logic [CW-1:0] cnt;
      logic          f;

      // level flips after FILT_LEN consecutive differing samples
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
          f   <= 1'b0;
        end else if (s2 == f) begin
          cnt <= '0;
        end else if (cnt == CW'(FILT_LEN - 1)) begin
          cnt <= '0;
          f   <= s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign q = f;
    end else begin : g_raw
      assign q = s2;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_d <= 1'b0;
    else        q_d <= q;
  end

  assign lvl  = q;
  assign rise = q & ~q_d;

endmodule

// File: rtl/k1_pulse_checker.sv
// K1 relay-drive pulse loopback checker: delay/width vs windows.
// Define K1_SENSE_FILTER_EN to deglitch the returned sense line.
module k1_pulse_checker
  import k1_chk_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int EXP_WIDTH = 4000,
  parameter int WIDTH_TOL = 8,
  parameter int MAX_DELAY = 16,
  parameter int TIMEOUT   = 8192,
  parameter int FILT_LEN  = 4
) (
  input logic              clk,
  input logic              rst_n,
  k1_pulse_checker_if.slave bus
);

`ifdef K1_SENSE_FILTER_EN
  localparam bit SENSE_FILT = 1'b1;
`else
  localparam bit SENSE_FILT = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MAXD =
    CNT_W'(MAX_DELAY);
  localparam logic [CNT_W-1:0] TMO =
    CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] W_LO =
    CNT_W'(EXP_WIDTH - WIDTH_TOL);
  localparam logic [CNT_W-1:0] W_HI =
    CNT_W'(EXP_WIDTH + WIDTH_TOL);

  logic t_rise;
  logic t_lvl_unused;
  logic s_rise;
  logic s_lvl;

  sync_edge #(
    .FILT_EN  (1'b0),
    .FILT_LEN (FILT_LEN)
  ) u_tem (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.tem),
    .lvl   (t_lvl_unused),
    .rise  (t_rise)
  );

  sync_edge #(
    .FILT_EN  (SENSE_FILT),
    .FILT_LEN (FILT_LEN)
  ) u_sense (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.k1_sense),
    .lvl   (s_lvl),
    .rise  (s_rise)
  );

  state_t             state;
  logic [CNT_W-1:0]   dcnt;
  logic [CNT_W-1:0]   wcnt;
  logic [CNT_W-1:0]   d_out;
  logic [CNT_W-1:0]   w_out;
  logic               done_q;
  logic               pass_q;
  logic [1:0]         fc_q;
  logic [TALLY_W-1:0] pcnt;
  logic [TALLY_W-1:0] fcnt;

  logic [CNT_W-1:0]   d_inc;
  logic [CNT_W-1:0]   w_inc;
  logic               fin;
  logic [1:0]         fin_code;
  logic [CNT_W-1:0]   fin_d;
  logic [CNT_W-1:0]   fin_w;

  // end-of-measurement decision, folded into the DONE entry
  always_comb begin
    d_inc    = dcnt + 1'b1;
    w_inc    = wcnt + 1'b1;
    fin      = 1'b0;
    fin_code = FC_OK;
    fin_d    = dcnt;
    fin_w    = wcnt;
    unique case (state)
      S_WAIT_RISE: begin
        if (!s_rise && d_inc == MAXD) begin
          fin      = 1'b1;
          fin_code = FC_NO_PULSE;
          fin_d    = d_inc;
          fin_w    = '0;
        end
      end
      S_MEASURE: begin
        if (!s_lvl) begin
          fin      = 1'b1;
          fin_code = (wcnt < W_LO || wcnt > W_HI)
                   ? FC_WIDTH : FC_OK;
        end else if (w_inc == TMO) begin
          fin      = 1'b1;
          fin_code = FC_STUCK;
          fin_w    = w_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      dcnt   <= '0;
      wcnt   <= '0;
      d_out  <= '0;
      w_out  <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fc_q   <= FC_OK;
      pcnt   <= '0;
      fcnt   <= '0;
    end else begin
      done_q <= 1'b0;
      if (!bus.enable) begin
        state <= S_IDLE;
      end else if (fin) begin
        state  <= S_DONE;
        done_q <= 1'b1;
        d_out  <= fin_d;
        w_out  <= fin_w;
        fc_q   <= fin_code;
        pass_q <= (fin_code == FC_OK);
        if (fin_code == FC_OK) pcnt <= sat_inc(pcnt);
        else                   fcnt <= sat_inc(fcnt);
      end else begin
        unique case (state)
          S_IDLE: begin
            if (t_rise) begin
              dcnt  <= '0;
              wcnt  <= s_rise ? CNT_W'(1) : '0;
              state <= s_rise ? S_MEASURE : S_WAIT_RISE;
            end
          end
          S_WAIT_RISE: begin
            dcnt <= d_inc;
            if (s_rise) begin
              wcnt  <= CNT_W'(1);
              state <= S_MEASURE;
            end
          end
          S_MEASURE: wcnt <= w_inc;
          S_DONE:    state <= S_IDLE;
          default:   state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_code  = fc_q;
  assign bus.delay_cnt  = d_out;
  assign bus.width_cnt  = w_out;
  assign bus.pass_count = pcnt;
  assign bus.fail_count = fcnt;

endmodule

// File: tb/tb_k1_pulse_checker.sv
// Scoreboard bench for k1_pulse_checker.
// Expected results are queued at stimulus time, popped on done.
module tb_k1_pulse_checker;
  import k1_chk_pkg::*;

  localparam int MAX_DELAY = 16;
  localparam int TIMEOUT   = 8192;
  localparam int EXP_W     = 4000;
  localparam int TOL       = 8;
`ifdef K1_SENSE_FILTER_EN
  localparam int FD = 4;
`else
  localparam int FD = 0;
`endif

  typedef struct {
    string tag;
    int    ps;
    int    fc;
    int    d;
    int    w;
    int    pc;
    int    fcn;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  k1_pulse_checker_if #(.CNT_W(16)) bus ();

  k1_pulse_checker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ndone = 0;
  exp_t q[$];
  int   m_pc = 0;
  int   m_fc = 0;
  exp_t last;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic push_exp(string tag, int dly, int hi,
                          bit present);
    exp_t e;
    e.tag = tag;
    if (!present || dly + FD > MAX_DELAY) begin
      e.fc = 1;
      e.d  = MAX_DELAY;
      e.w  = 0;
    end else if (hi >= TIMEOUT) begin
      e.fc = 3;
      e.d  = dly + FD;
      e.w  = TIMEOUT;
    end else begin
      e.d  = dly + FD;
      e.w  = hi;
      e.fc = (hi < EXP_W - TOL || hi > EXP_W + TOL) ? 2 : 0;
    end
    e.ps = (e.fc == 0) ? 1 : 0;
    if (e.ps == 1) m_pc = (m_pc == 65535) ? m_pc : m_pc + 1;
    else           m_fc = (m_fc == 65535) ? m_fc : m_fc + 1;
    e.pc  = m_pc;
    e.fcn = m_fc;
    last  = e;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      ndone++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk({e.tag, "_pass"},  32'(bus.pass),       e.ps);
        chk({e.tag, "_fcode"}, 32'(bus.fail_code),  e.fc);
        chk({e.tag, "_delay"}, 32'(bus.delay_cnt),  e.d);
        chk({e.tag, "_width"}, 32'(bus.width_cnt),  e.w);
        chk({e.tag, "_pcnt"},  32'(bus.pass_count), e.pc);
        chk({e.tag, "_fcnt"},  32'(bus.fail_count), e.fcn);
      end
    end
  end

  task automatic wait_done(int target, int budget);
    int i;
    for (i = 0; i < budget && ndone < target; i++)
      @(negedge clk);
    if (ndone < target) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_pulse(string tag, int dly, int hi,
                           bit present, bit retrig);
    int n0 = ndone;
    push_exp(tag, dly, hi, present);
    @(negedge clk);
    bus.tem = 1'b1;
    if (present) begin
      repeat (dly) @(negedge clk);
      bus.k1_sense = 1'b1;
      for (int i = 0; i < hi; i++) begin
        @(negedge clk);
        if (retrig && i == 50) bus.tem = 1'b0;
        if (retrig && i == 53) bus.tem = 1'b1;
      end
      bus.k1_sense = 1'b0;
    end
    wait_done(n0 + 1, 60);
    bus.tem = 1'b0;
    repeat (8) @(negedge clk);
    chk({tag, "_ndone"}, 32'(ndone - n0), 32'd1);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"},  32'(bus.busy),       32'd0);
    chk({tag, "_done"},  32'(bus.done),       32'd0);
    chk({tag, "_pass"},  32'(bus.pass),       32'd0);
    chk({tag, "_fcode"}, 32'(bus.fail_code),  32'd0);
    chk({tag, "_delay"}, 32'(bus.delay_cnt),  32'd0);
    chk({tag, "_width"}, 32'(bus.width_cnt),  32'd0);
    chk({tag, "_pcnt"},  32'(bus.pass_count), 32'd0);
    chk({tag, "_fcnt"},  32'(bus.fail_count), 32'd0);
  endtask

  initial begin
    int n0;
    bus.enable   = 1'b1;
    bus.tem      = 1'b0;
    bus.k1_sense = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_pulse("nominal", 2, 4000, 1'b1, 1'b0);
    run_pulse("lo_edge", 3, 3992, 1'b1, 1'b0);
    run_pulse("hi_edge", 1, 4008, 1'b1, 1'b0);
    run_pulse("lo_tol", 2, 3991, 1'b1, 1'b0);
    run_pulse("hi_tol", 2, 4009, 1'b1, 1'b0);
    run_pulse("too_short", 2, 3990, 1'b1, 1'b0);
    run_pulse("no_pulse", 0, 0, 1'b0, 1'b0);
    run_pulse("stuck", 2, 9000, 1'b1, 1'b0);
    run_pulse("same_cyc", 0, 4000, 1'b1, 1'b1);
    run_pulse("late_rise", MAX_DELAY - FD, 4004, 1'b1, 1'b0);

    // enable dropped mid-measurement: no done, results held
    n0 = ndone;
    @(negedge clk);
    bus.tem = 1'b1;
    repeat (2) @(negedge clk);
    bus.k1_sense = 1'b1;
    repeat (100) @(negedge clk);
    chk("en_busy_pre", 32'(bus.busy), 32'd1);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("en_busy_post", 32'(bus.busy), 32'd0);
    bus.k1_sense = 1'b0;
    bus.tem = 1'b0;
    repeat (6) @(negedge clk);
    bus.enable = 1'b1;
    repeat (6) @(negedge clk);
    chk("en_ndone", 32'(ndone - n0), 32'd0);
    chk("en_pass",  32'(bus.pass),       last.ps);
    chk("en_fcode", 32'(bus.fail_code),  last.fc);
    chk("en_delay", 32'(bus.delay_cnt),  last.d);
    chk("en_width", 32'(bus.width_cnt),  last.w);
    chk("en_pcnt",  32'(bus.pass_count), last.pc);
    chk("en_fcnt",  32'(bus.fail_count), last.fcn);

    run_pulse("after_en", 4, 4000, 1'b1, 1'b0);

    // asynchronous reset in the middle of a measurement
    @(negedge clk);
    bus.tem = 1'b1;
    repeat (2) @(negedge clk);
    bus.k1_sense = 1'b1;
    repeat (50) @(negedge clk);
    chk("rst_busy_pre", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    m_pc = 0;
    m_fc = 0;
    bus.tem = 1'b0;
    bus.k1_sense = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_pulse("post_rst", 2, 4000, 1'b1, 1'b0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
